// File: rtl/draw_pkg.sv
// Shared definitions for the VGA rectangle drawing path:
// FSM state encoding, visible screen size and the erase colour.
package draw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int BLACK    = 0;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major cx/cy raster counter for the rectangle drawer.
// last flags the final pixel (cx = w-1, cy = h-1).
module rect_scan_counter #(
   parameter int CX_W = 5,
   parameter int CY_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   input  logic [CX_W-1:0] w,
   input  logic [CY_W-1:0] h,
   output logic [CX_W-1:0] cx,
   output logic [CY_W-1:0] cy,
   output logic            last
);

   logic [CX_W-1:0] cx_q, cx_d;
   logic [CY_W-1:0] cy_q, cy_d;
   logic            row_end;
   logic            col_end;

   // cx+1 == w avoids the w-1 underflow when w is zero
   assign row_end = (cx_q + CX_W'(1)) == w;
   assign col_end = (cy_q + CY_W'(1)) == h;
   assign last    = row_end && col_end;
   assign cx      = cx_q;
   assign cy      = cy_q;

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clear) begin
         cx_d = '0;
         cy_d = '0;
      end else if (enable) begin
         if (row_end) begin
            cx_d = '0;
            cy_d = col_end ? '0 : cy_q + CY_W'(1);
         end else begin
            cx_d = cx_q + CX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

endmodule

// File: rtl/rect_draw.sv
// Rectangle rasteriser: latches a request on go, then emits one
// clipped pixel per clock in row-major order, then pulses done.
module rect_draw #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int MAX_W    = 16,
   parameter int MAX_H    = 16,
   parameter int SCREEN_W = draw_pkg::SCREEN_W,
   parameter int SCREEN_H = draw_pkg::SCREEN_H,
   localparam int WW      = $clog2(MAX_W + 1),
   localparam int HW      = $clog2(MAX_H + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic [X_W-1:0]      x_in,
   input  logic [Y_W-1:0]      y_in,
   input  logic [WW-1:0]       w_in,
   input  logic [HW-1:0]       h_in,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                draw,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   import draw_pkg::*;

   state_e state_q, state_d;

   logic [X_W-1:0]      x0_q;
   logic [Y_W-1:0]      y0_q;
   logic [COLOUR_W-1:0] col_q;
   logic [WW-1:0]       w_q, w_sat;
   logic [HW-1:0]       h_q, h_sat;
   logic [WW-1:0]       cx;
   logic [HW-1:0]       cy;
   logic                last;
   logic                accept;
   logic                in_draw;
   logic [X_W:0]        sum_x;
   logic [Y_W:0]        sum_y;
   logic                on_screen;

   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      y_q;
   logic [COLOUR_W-1:0] colour_q;
   logic                plot_q, busy_q, done_q;

   assign w_sat   = (w_in > WW'(MAX_W)) ? WW'(MAX_W) : w_in;
   assign h_sat   = (h_in > HW'(MAX_H)) ? HW'(MAX_H) : h_in;
   assign accept  = (state_q == IDLE) && go;
   assign in_draw = (state_q == DRAW);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (go) state_d = (w_sat == '0 || h_sat == '0) ? DONE : DRAW;
         DRAW: if (last) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_q  <= '0;
         y0_q  <= '0;
         col_q <= '0;
         w_q   <= '0;
         h_q   <= '0;
      end else if (accept) begin
         x0_q  <= x_in;
         y0_q  <= y_in;
         col_q <= draw ? colour_in : COLOUR_W'(BLACK);
         w_q   <= w_sat;
         h_q   <= h_sat;
      end
   end

   rect_scan_counter #(
      .CX_W (WW),
      .CY_W (HW)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clear  (!in_draw),
      .enable (in_draw),
      .w      (w_q),
      .h      (h_q),
      .cx     (cx),
      .cy     (cy),
      .last   (last)
   );

   // one extra bit so off-screen sums never wrap back on-screen
   assign sum_x     = (X_W+1)'(x0_q) + (X_W+1)'(cx);
   assign sum_y     = (Y_W+1)'(y0_q) + (Y_W+1)'(cy);
   assign on_screen = (sum_x < (X_W+1)'(SCREEN_W)) &&
                      (sum_y < (Y_W+1)'(SCREEN_H));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         plot_q <= in_draw && on_screen;
         busy_q <= in_draw;
         done_q <= (state_q == DONE);
         if (in_draw) begin
            x_q      <= sum_x[X_W-1:0];
            y_q      <= sum_y[Y_W-1:0];
            colour_q <= col_q;
         end
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = colour_q;
   assign plot       = plot_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_rect_draw.sv
// Directed testbench for rect_draw with hand-computed pixel streams.
module tb_rect_draw;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       go = 1'b0;
   logic [7:0] x_in = '0;
   logic [6:0] y_in = '0;
   logic [4:0] w_in = '0;
   logic [4:0] h_in = '0;
   logic [2:0] colour_in = '0;
   logic       draw = 1'b0;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot, busy, done;

   int checks = 0;
   int failures = 0;

   logic [20:0] obs;
   logic [20:0] exp_v;
   logic [2:0]  ctl;

   rect_draw dut (
      .clk        (clk),
      .reset      (reset),
      .go         (go),
      .x_in       (x_in),
      .y_in       (y_in),
      .w_in       (w_in),
      .h_in       (h_in),
      .colour_in  (colour_in),
      .draw       (draw),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign obs = {plot, busy, done, x_out, y_out, colour_out};
   assign ctl = {plot, busy, done};

   task automatic set_in(input int x, input int y, input int w,
                         input int h, input int c, input int d);
      x_in      = x[7:0];
      y_in      = y[6:0];
      w_in      = w[4:0];
      h_in      = h[4:0];
      colour_in = c[2:0];
      draw      = d[0];
   endtask

   task automatic start(input int x, input int y, input int w,
                        input int h, input int c, input int d);
      set_in(x, y, w, h, c, d);
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (obs !== 21'd0) begin
         failures++;
         $display("FAIL reset obs=%h exp=0", obs);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int busy_cnt = 0;
      start(10, 20, 4, 4, 5, 1);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(10 + i % 4), 7'(20 + i / 4), 3'b101};
         if (busy) busy_cnt++;
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL basic px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL basic_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b000 || busy_cnt != 16) begin
         failures++;
         $display("FAIL basic_end ctl=%b busy_cnt=%0d exp 000/16",
                  ctl, busy_cnt);
      end
   endtask

   task automatic test_erase;
      start(0, 0, 2, 3, 7, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(i % 2), 7'(i / 2), 3'b000};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL erase px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL erase_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_clip;
      int plots = 0;
      int ex, ey;
      start(158, 118, 4, 4, 2, 1);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         ex = 158 + i % 4;
         ey = 118 + i / 4;
         if (plot) plots++;
         checks++;
         if (ex < 160 && ey < 120) begin
            exp_v = {3'b110, 8'(ex), 7'(ey), 3'b010};
            if (obs !== exp_v) begin
               failures++;
               $display("FAIL clip px%0d obs=%h exp=%h", i, obs, exp_v);
            end
         end else if (ctl !== 3'b010) begin
            failures++;
            $display("FAIL clip_off px%0d ctl=%b exp=010", i, ctl);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001 || plots != 4) begin
         failures++;
         $display("FAIL clip_done ctl=%b plots=%0d exp 001/4", ctl, plots);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_degenerate;
      start(5, 5, 0, 5, 1, 1);
      checks++;
      if (ctl !== 3'b000) begin
         failures++;
         $display("FAIL zero_w_accept ctl=%b exp=000", ctl);
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL zero_w_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b000) begin
         failures++;
         $display("FAIL zero_w_idle ctl=%b exp=000", ctl);
      end
      start(0, 60, 31, 1, 6, 1);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(i), 7'(60), 3'b110};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL sat px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL sat_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_go_busy;
      start(5, 5, 3, 2, 2, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(5 + i % 3), 7'(5 + i / 3), 3'b010};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL busy_go px%0d obs=%h exp=%h", i, obs, exp_v);
         end
         if (i == 1) begin
            set_in(50, 50, 4, 4, 7, 1);
            go = 1'b1;
         end
         if (i == 2) go = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL busy_go_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b000) begin
         failures++;
         $display("FAIL busy_go_idle ctl=%b exp=000", ctl);
      end
   endtask

   task automatic test_back_to_back;
      set_in(1, 2, 2, 1, 4, 1);
      go = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(1 + i), 7'(2), 3'b100};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL b2b px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL b2b_done ctl=%b exp=001", ctl);
      end
      set_in(30, 40, 1, 1, 3, 1);
      @(posedge clk); #1;
      go = 1'b0;
      checks++;
      if (ctl !== 3'b000) begin
         failures++;
         $display("FAIL b2b_idle ctl=%b exp=000", ctl);
      end
      @(posedge clk); #1;
      exp_v = {3'b110, 8'(30), 7'(40), 3'b011};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL b2b_second obs=%h exp=%h", obs, exp_v);
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL b2b_second_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      start(10, 10, 4, 4, 5, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(10 + i % 4), 7'(10 + i / 4), 3'b101};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rst_mid px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 21'd0) begin
         failures++;
         $display("FAIL rst_async obs=%h exp=0", obs);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ctl !== 3'b000) begin
            failures++;
            $display("FAIL rst_no_done cyc%0d ctl=%b exp=000", i, ctl);
         end
      end
      start(40, 50, 2, 2, 1, 1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         exp_v = {3'b110, 8'(40 + i % 2), 7'(50 + i / 2), 3'b001};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL rst_redraw px%0d obs=%h exp=%h", i, obs, exp_v);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (ctl !== 3'b001) begin
         failures++;
         $display("FAIL rst_redraw_done ctl=%b exp=001", ctl);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_erase;
      test_clip;
      test_degenerate;
      test_go_busy;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
